// File: rtl/mpsk_symbol_tx.sv
// MPSK (BPSK/QPSK) symbol mapper with rectangular upsampling by SPS.
// Symbol bits enter a one-entry holding register through a valid/ready
// handshake. The current symbol's Gray-coded constellation point is
// emitted on each sample_en tick, and each symbol lasts SPS ticks.
module mpsk_symbol_tx #(
    parameter int unsigned SYM_WIDTH    = 1,
    parameter int unsigned INT_WIDTH    = 1,
    parameter int unsigned DEC_WIDTH    = 14,
    parameter int unsigned BITS_PER_SYM = 2,
    parameter int unsigned SPS          = 4,
    parameter int unsigned AMP          = 11585
) (
    input  logic                                              clk,
    input  logic                                              rstn,
    input  logic                                              sample_en,
    input  logic                                              data_ready,
    input  logic [BITS_PER_SYM-1:0]                           bit_data,
    output logic                                              bit_ready,
    output logic                                              data_valid,
    output logic signed [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0]   MapperOutputDataI,
    output logic signed [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0]   MapperOutputDataQ,
    output logic                                              underrun
);

    localparam int unsigned W     = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
    localparam int unsigned CNT_W = $clog2(SPS);

    localparam logic signed [W-1:0]     AMP_P    = W'(AMP);
    localparam logic signed [W-1:0]     AMP_N    = -AMP_P;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SPS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BITS_PER_SYM-1:0] sym_q, sym_d;
    logic [BITS_PER_SYM-1:0] hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    data_valid_q, data_valid_d;
    logic                    underrun_q, underrun_d;
    logic signed [W-1:0]     out_i_q, out_i_d;
    logic signed [W-1:0]     out_q_q, out_q_d;

    logic                    load_now;
    logic                    emit;
    logic                    accept;
    logic [BITS_PER_SYM-1:0] emit_sym;
    logic signed [W-1:0]     map_i;
    logic signed [W-1:0]     map_q;

    // In IDLE the first sample comes straight from the holding register.
    assign emit_sym = (state_q == IDLE) ? hold_q : sym_q;

    // Gray-coded constellation lookup for the symbol being emitted
    if (BITS_PER_SYM == 2) begin : g_qpsk
        always_comb begin
            map_i = emit_sym[1] ? AMP_N : AMP_P;
            map_q = emit_sym[0] ? AMP_N : AMP_P;
        end
    end else begin : g_bpsk
        always_comb begin
            map_i = emit_sym[0] ? AMP_N : AMP_P;
            map_q = '0;
        end
    end

    // Symbol sequencing, holding-register handshake and output next-state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sym_d        = sym_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        data_valid_d = 1'b0;
        underrun_d   = 1'b0;
        out_i_d      = out_i_q;
        out_q_d      = out_q_q;
        load_now     = 1'b0;
        emit         = 1'b0;

        if (sample_en) begin
            case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        load_now = 1'b1;
                        emit     = 1'b1;
                        cnt_d    = CNT_W'(1);
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    emit = 1'b1;
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = CNT_W'(cnt_q + 1'b1);
                    end else begin
                        cnt_d = '0;
                        if (hold_full_q) begin
                            load_now = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            underrun_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (emit) begin
            data_valid_d = 1'b1;
            out_i_d      = map_i;
            out_q_d      = map_q;
        end

        if (load_now) begin
            sym_d       = hold_q;
            hold_full_d = 1'b0;
        end

        bit_ready = ~hold_full_q | load_now;
        accept    = data_ready & bit_ready;

        if (accept) begin
            hold_d      = bit_data;
            hold_full_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sym_q        <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            data_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
            out_i_q      <= '0;
            out_q_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sym_q        <= sym_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            data_valid_q <= data_valid_d;
            underrun_q   <= underrun_d;
            out_i_q      <= out_i_d;
            out_q_q      <= out_q_d;
        end
    end

    assign data_valid        = data_valid_q;
    assign underrun          = underrun_q;
    assign MapperOutputDataI = out_i_q;
    assign MapperOutputDataQ = out_q_q;

endmodule

// File: tb/tb_mpsk_symbol_tx.sv
// Directed bench for mpsk_symbol_tx: one QPSK and one BPSK instance.
module tb_mpsk_symbol_tx;

    logic clk        = 1'b0;
    logic rstn       = 1'b0;
    logic sample_en  = 1'b0;
    logic data_ready = 1'b0;
    logic sel_b      = 1'b0;
    logic [1:0] bit_data = 2'b00;

    logic dr_q, dr_b;
    assign dr_q = data_ready & ~sel_b;
    assign dr_b = data_ready & sel_b;

    logic               bit_ready, dv, ur;
    logic signed [15:0] out_i, out_q;
    logic               bit_ready_b, dv_b, ur_b;
    logic signed [15:0] out_i_b, out_q_b;

    mpsk_symbol_tx dut (
        .clk               (clk),
        .rstn              (rstn),
        .sample_en         (sample_en),
        .data_ready        (dr_q),
        .bit_data          (bit_data),
        .bit_ready         (bit_ready),
        .data_valid        (dv),
        .MapperOutputDataI (out_i),
        .MapperOutputDataQ (out_q),
        .underrun          (ur)
    );

    mpsk_symbol_tx #(.BITS_PER_SYM(1), .AMP(16384)) dut_b (
        .clk               (clk),
        .rstn              (rstn),
        .sample_en         (sample_en),
        .data_ready        (dr_b),
        .bit_data          (bit_data[0]),
        .bit_ready         (bit_ready_b),
        .data_valid        (dv_b),
        .MapperOutputDataI (out_i_b),
        .MapperOutputDataQ (out_q_b),
        .underrun          (ur_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
        int ur;
        int cyc;
    } samp_t;

    samp_t      mon_q[$];
    samp_t      mon_b[$];
    logic [1:0] tx[$];
    int         cyc       = 0;
    int         orphan_ur = 0;
    int         max_blk   = 0;
    int         checks    = 0;
    int         errors    = 0;

    // Stream expectations for symbols 00, 01, 11, 10
    int st_i[4] = '{11585, 11585, -11585, -11585};
    int st_q[4] = '{11585, -11585, -11585, 11585};
    // Backpressure expectations for symbols 00, 11, 01
    int bp_i[3] = '{11585, -11585, 11585};
    int bp_q[3] = '{11585, -11585, -11585};

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid sample midway between active edges
    always @(negedge clk) begin
        if (dv)
            mon_q.push_back('{int'(out_i), int'(out_q), int'(ur), cyc});
        if (dv_b)
            mon_b.push_back('{int'(out_i_b), int'(out_q_b), int'(ur_b), cyc});
        if ((ur && !dv) || (ur_b && !dv_b))
            orphan_ur++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive queued symbols and a periodic sample_en for n cycles
    task automatic run(input int n, input int period, input logic use_b);
        int   blk;
        logic rdy, acc;
        blk = 0;
        for (int i = 0; i < n; i++) begin
            sample_en = (period > 0) && (i % period == 0);
            if (tx.size() > 0) begin
                data_ready = 1'b1;
                bit_data   = tx[0];
            end else begin
                data_ready = 1'b0;
            end
            #1;
            rdy = use_b ? bit_ready_b : bit_ready;
            acc = data_ready && rdy;
            if (data_ready && !rdy) blk++;
            else blk = 0;
            if (blk > max_blk) max_blk = blk;
            @(posedge clk);
            #1;
            if (acc) void'(tx.pop_front());
        end
        sample_en  = 1'b0;
        data_ready = 1'b0;
    endtask

    initial begin
        // Reset with random inputs
        for (int k = 0; k < 2; k++) begin
            sample_en  = 1'($urandom);
            data_ready = 1'($urandom);
            bit_data   = 2'($urandom);
            tick();
            check("rst_valid", int'(dv), 0);
            check("rst_underrun", int'(ur), 0);
            check("rst_i", int'(out_i), 0);
            check("rst_q", int'(out_q), 0);
        end
        rstn       = 1'b1;
        sample_en  = 1'b0;
        data_ready = 1'b0;
        #1;
        check("rst_bit_ready", int'(bit_ready), 1);
        check("rst_bit_ready_b", int'(bit_ready_b), 1);
        tick();

        // QPSK single symbol, sample_en every 3rd cycle
        mon_q.delete();
        tx = '{2'b01};
        run(40, 3, 1'b0);
        check("single_count", mon_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < mon_q.size()) begin
                check($sformatf("single_i[%0d]", k), mon_q[k].i, 11585);
                check($sformatf("single_q[%0d]", k), mon_q[k].q, -11585);
                check($sformatf("single_ur[%0d]", k), mon_q[k].ur, (k == 3) ? 1 : 0);
            end
        end

        // Back-to-back stream, sample_en every cycle
        mon_q.delete();
        max_blk = 0;
        tx = '{2'b00, 2'b01, 2'b11, 2'b10};
        run(30, 1, 1'b0);
        check("stream_count", mon_q.size(), 16);
        for (int k = 0; k < 16; k++) begin
            if (k < mon_q.size()) begin
                check($sformatf("stream_i[%0d]", k), mon_q[k].i, st_i[k/4]);
                check($sformatf("stream_q[%0d]", k), mon_q[k].q, st_q[k/4]);
                check($sformatf("stream_ur[%0d]", k), mon_q[k].ur, (k == 15) ? 1 : 0);
            end
        end
        if (mon_q.size() == 16)
            check("stream_contiguous", mon_q[15].cyc - mon_q[0].cyc, 15);
        check("stream_block_le4", int'(max_blk <= 4), 1);

        // Backpressure: stall sample_en with a symbol held
        mon_q.delete();
        sample_en  = 1'b0;
        data_ready = 1'b1;
        bit_data   = 2'b00;
        #1;
        check("bp_ready_empty", int'(bit_ready), 1);
        tick();
        bit_data = 2'b11;
        #1;
        check("bp_ready_held_idle", int'(bit_ready), 0);
        tick();
        sample_en = 1'b1;
        #1;
        check("bp_ready_load", int'(bit_ready), 1);
        tick();
        sample_en = 1'b0;
        bit_data  = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_ready_stall[%0d]", k), int'(bit_ready), 0);
            tick();
        end
        data_ready = 1'b0;
        tx = '{2'b01};
        run(40, 2, 1'b0);
        check("bp_count", mon_q.size(), 12);
        for (int k = 0; k < 12; k++) begin
            if (k < mon_q.size()) begin
                check($sformatf("bp_i[%0d]", k), mon_q[k].i, bp_i[k/4]);
                check($sformatf("bp_q[%0d]", k), mon_q[k].q, bp_q[k/4]);
            end
        end

        // BPSK instance, bits 1 then 0
        mon_b.delete();
        sel_b = 1'b1;
        tx = '{2'b01, 2'b00};
        run(40, 2, 1'b1);
        sel_b = 1'b0;
        check("bpsk_count", mon_b.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < mon_b.size()) begin
                check($sformatf("bpsk_i[%0d]", k), mon_b[k].i, (k < 4) ? -16384 : 16384);
                check($sformatf("bpsk_q[%0d]", k), mon_b[k].q, 0);
                check($sformatf("bpsk_ur[%0d]", k), mon_b[k].ur, (k == 7) ? 1 : 0);
            end
        end

        // Reset after 2 of 4 samples with one symbol held
        mon_q.delete();
        sample_en  = 1'b0;
        data_ready = 1'b1;
        bit_data   = 2'b10;
        tick();
        sample_en = 1'b1;
        bit_data  = 2'b01;
        tick();
        data_ready = 1'b0;
        tick();
        sample_en = 1'b0;
        tick();
        check("mid_before_count", mon_q.size(), 2);
        rstn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample_en = 1'($urandom);
            tick();
            check($sformatf("mid_rst_valid[%0d]", k), int'(dv), 0);
            check($sformatf("mid_rst_i[%0d]", k), int'(out_i), 0);
        end
        check("mid_rst_count", mon_q.size(), 2);
        rstn      = 1'b1;
        sample_en = 1'b0;
        tick();
        mon_q.delete();
        tx = '{2'b11};
        run(30, 2, 1'b0);
        check("mid_after_count", mon_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < mon_q.size()) begin
                check($sformatf("mid_after_i[%0d]", k), mon_q[k].i, -11585);
                check($sformatf("mid_after_q[%0d]", k), mon_q[k].q, -11585);
                check($sformatf("mid_after_ur[%0d]", k), mon_q[k].ur, (k == 3) ? 1 : 0);
            end
        end

        check("orphan_underrun", orphan_ur, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
